vga_scanout: RTL and testbench

Scan-out controller that sits directly downstream of the VGA framebuffer memory. It generates the raster timing (hsync, vsync, data-enable) and drives the framebuffer read address. It captures the returned pixel and presents it, aligned with the sync signals, to the DAC/pins. A reduced-resolution framebuffer is supported by pixel/line replication with a power-of-two scale factor.

---
 rtl/vga_pkg.sv | 22 ++
 rtl/vga_axis_counter.sv | 47 ++++
 rtl/vga_scanout.sv | 156 +++++++++++++++
 tb/tb_vga_scanout.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg
// Shared VGA raster definitions: a per-axis timing record, the default
// 640x480@60 timing for each axis, and a helper that derives the total
// axis length (visible + porches + sync) from a timing record.
// No ports; imported by vga_axis_counter and vga_scanout.
package vga_pkg;

    typedef struct packed {
        int visible;
        int front;
        int sync;
        int back;
    } vga_timing_t;

    localparam vga_timing_t VGA_H_640 = '{visible: 640, front: 16, sync: 96, back: 48};
    localparam vga_timing_t VGA_V_480 = '{visible: 480, front: 10, sync: 2,  back: 33};

    function automatic int timing_total(input vga_timing_t t);
        return t.visible + t.front + t.sync + t.back;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
// One raster axis (horizontal or vertical). Counts 0..TOTAL-1, advancing
// only when step is high, and decodes the visible and sync windows from
// the current count.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset (count -> 0)
//   step     in   advance the count by one this cycle
//   count    out  current position on this axis
//   wrap     out  high when step is high and count is at its last value
//   visible  out  count lies in the visible region
//   sync     out  count lies in the sync window (active high, polarity
//                 is applied by the caller)
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter vga_timing_t TIMING = VGA_H_640,
    parameter int          CW     = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    output logic [CW-1:0] count,
    output logic          wrap,
    output logic          visible,
    output logic          sync
);

    localparam int          TOTAL      = timing_total(TIMING);
    localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
    localparam logic [CW-1:0] VIS_END    = CW'(TIMING.visible);
    localparam logic [CW-1:0] SYNC_START = CW'(TIMING.visible + TIMING.front);
    localparam logic [CW-1:0] SYNC_END   = CW'(TIMING.visible + TIMING.front + TIMING.sync);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (step) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

    assign wrap    = step && (count == LAST);
    assign visible = (count < VIS_END);
    assign sync    = (count >= SYNC_START) && (count < SYNC_END);

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout
// Raster scan-out controller. Generates hsync/vsync/de, drives the
// framebuffer read address for a framebuffer reduced by 2^SCALE_SHIFT in
// each direction (pixel and line replication), and registers the
// returned pixel so that it stays aligned with the syncs.
// Optional feature macro: VGA_SCANOUT_BORDER_EN adds parameter
// BORDER_COLOR and paints the outermost visible ring with it.
// Ports:
//   clk           in   system clock
//   rst           in   synchronous active-high reset
//   pix_ce        in   pixel clock enable; all state advances only when high
//   fb_read_addr  out  framebuffer read address (row_base + col)
//   fb_data       in   framebuffer data, combinational from fb_read_addr
//   pixel         out  registered pixel, 0 outside the visible area
//   de            out  registered data enable
//   hsync/vsync   out  registered syncs, active level SYNC_POL
//   frame_start   out  one-clock pulse when pixel (0,0) is registered
module vga_scanout
    import vga_pkg::*;
#(
    parameter int         H_VISIBLE   = VGA_H_640.visible,
    parameter int         H_FRONT     = VGA_H_640.front,
    parameter int         H_SYNC      = VGA_H_640.sync,
    parameter int         H_BACK      = VGA_H_640.back,
    parameter int         V_VISIBLE   = VGA_V_480.visible,
    parameter int         V_FRONT     = VGA_V_480.front,
    parameter int         V_SYNC      = VGA_V_480.sync,
    parameter int         V_BACK      = VGA_V_480.back,
    parameter logic       SYNC_POL    = 1'b0,
    parameter int         SCALE_SHIFT = 2,
    parameter int         WIDTH       = 8,
`ifdef VGA_SCANOUT_BORDER_EN
    parameter logic [WIDTH-1:0] BORDER_COLOR = '1,
`endif
    parameter int         FB_SIZE     = (H_VISIBLE >> SCALE_SHIFT) * (V_VISIBLE >> SCALE_SHIFT)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pix_ce,
    output logic [$clog2(FB_SIZE)-1:0] fb_read_addr,
    input  logic [WIDTH-1:0]           fb_data,
    output logic [WIDTH-1:0]           pixel,
    output logic                       de,
    output logic                       hsync,
    output logic                       vsync,
    output logic                       frame_start
);

    localparam vga_timing_t H_T = '{visible: H_VISIBLE, front: H_FRONT, sync: H_SYNC, back: H_BACK};
    localparam vga_timing_t V_T = '{visible: V_VISIBLE, front: V_FRONT, sync: V_SYNC, back: V_BACK};
    localparam int HW = $clog2(timing_total(H_T));
    localparam int VW = $clog2(timing_total(V_T));
    localparam int AW = $clog2(FB_SIZE);

    localparam logic [HW-1:0] H_LAST_VIS = HW'(H_VISIBLE - 1);
    localparam logic [VW-1:0] V_LAST_VIS = VW'(V_VISIBLE - 1);
    localparam logic [HW-1:0] H_MASK     = HW'((1 << SCALE_SHIFT) - 1);
    localparam logic [VW-1:0] V_MASK     = VW'((1 << SCALE_SHIFT) - 1);
    localparam logic [AW-1:0] ROW_STEP   = AW'(H_VISIBLE >> SCALE_SHIFT);

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          h_wrap, h_vis, h_sync;
    logic          v_wrap, v_vis, v_sync;
    logic [AW-1:0] col, row_base;
    logic          visible;

    vga_axis_counter #(.TIMING(H_T), .CW(HW)) u_h_counter (
        .clk     (clk),
        .rst     (rst),
        .step    (pix_ce),
        .count   (h),
        .wrap    (h_wrap),
        .visible (h_vis),
        .sync    (h_sync)
    );

    // The vertical axis steps once per line; h_wrap already includes pix_ce.
    vga_axis_counter #(.TIMING(V_T), .CW(VW)) u_v_counter (
        .clk     (clk),
        .rst     (rst),
        .step    (h_wrap),
        .count   (v),
        .wrap    (v_wrap),
        .visible (v_vis),
        .sync    (v_sync)
    );

    // Column advances after the last replica of each source pixel. The
    // final visible pixel is excluded so col parks on the last column
    // through horizontal blanking instead of running off the row.
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
        end else if (pix_ce) begin
            if (h_wrap) begin
                col <= '0;
            end else if (h_vis && ((h & H_MASK) == H_MASK) && (h != H_LAST_VIS)) begin
                col <= col + AW'(1);
            end
        end
    end

    // Row base moves to the next source row after the last replicated line.
    // The last visible line is excluded so the base parks on the final row
    // during vertical blanking and the address never leaves the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_base <= '0;
        end else if (v_wrap) begin
            row_base <= '0;
        end else if (h_wrap && v_vis && ((v & V_MASK) == V_MASK) && (v != V_LAST_VIS)) begin
            row_base <= row_base + ROW_STEP;
        end
    end

    assign fb_read_addr = row_base + col;
    assign visible      = h_vis && v_vis;

    // Output stage: every registered output is taken from the same counter
    // state, keeping pixel, de and syncs aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            pixel <= '0;
            de    <= 1'b0;
            hsync <= ~SYNC_POL;
            vsync <= ~SYNC_POL;
        end else if (pix_ce) begin
`ifdef VGA_SCANOUT_BORDER_EN
            if (!visible) begin
                pixel <= '0;
            end else if ((h == '0) || (h == H_LAST_VIS) || (v == '0) || (v == V_LAST_VIS)) begin
                pixel <= BORDER_COLOR;
            end else begin
                pixel <= fb_data;
            end
`else
            pixel <= visible ? fb_data : '0;
`endif
            de    <= visible;
            hsync <= h_sync ? SYNC_POL : ~SYNC_POL;
            vsync <= v_sync ? SYNC_POL : ~SYNC_POL;
        end
    end

    // frame_start is rebuilt every clock so it lasts exactly one clock even
    // when pix_ce is slower than clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_ce && (h == '0) && (v == '0);
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout
// Self-checking bench for vga_scanout using a shrunken raster so several
// frames fit in a short run. A position-based reference model predicts
// every output each clock. Honours VGA_SCANOUT_BORDER_EN when defined.
module tb_vga_scanout;

    localparam int HV = 32, HF = 4, HS = 6, HB = 6;
    localparam int VV = 16, VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int S   = 2;
    localparam int W   = 8;
    localparam int FBW = HV >> S;
    localparam int FBS = (HV >> S) * (VV >> S);
    localparam int AW  = $clog2(FBS);
    localparam logic POL = 1'b0;

    logic          clk;
    logic          rst;
    logic          pix_ce;
    logic [AW-1:0] fb_read_addr;
    logic [W-1:0]  fb_data;
    logic [W-1:0]  pixel;
    logic          de, hsync, vsync, frame_start;

    logic [W-1:0]  fb_mem [FBS];

    int mx, my;
    logic [W-1:0] e_pixel;
    logic         e_de, e_hs, e_vs, e_fs;
    int checkCount, passCount, cycle;

    vga_scanout #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(POL), .SCALE_SHIFT(S), .WIDTH(W), .FB_SIZE(FBS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pix_ce       (pix_ce),
        .fb_read_addr (fb_read_addr),
        .fb_data      (fb_data),
        .pixel        (pixel),
        .de           (de),
        .hsync        (hsync),
        .vsync        (vsync),
        .frame_start  (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb fb_data = fb_mem[fb_read_addr];

    // Address the controller should be presenting for raster position (x,y):
    // the source pixel under it, clamped to the last column/row in blanking.
    function automatic int modelAddr(input int x, input int y);
        int cx, ry;
        cx = ((x < HV) ? x : HV - 1) >> S;
        ry = ((y < VV) ? y : VV - 1) >> S;
        return ry * FBW + cx;
    endfunction

    function automatic logic [W-1:0] modelPixel(input int x, input int y);
        if (!(x < HV && y < VV)) return '0;
`ifdef VGA_SCANOUT_BORDER_EN
        if (x == 0 || x == HV - 1 || y == 0 || y == VV - 1) return '1;
`endif
        return fb_mem[(y >> S) * FBW + (x >> S)];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d, x=%0d y=%0d)",
                     tag, got, exp, cycle, mx, my);
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, compare after it.
    task automatic applyStimulus(input logic ce_in, input logic rst_in);
        @(negedge clk);
        pix_ce = ce_in;
        rst    = rst_in;
        @(posedge clk);
        if (rst_in) begin
            e_pixel = '0; e_de = 1'b0; e_hs = ~POL; e_vs = ~POL; e_fs = 1'b0;
            mx = 0; my = 0;
        end else begin
            e_fs = ce_in && (mx == 0) && (my == 0);
            if (ce_in) begin
                e_pixel = modelPixel(mx, my);
                e_de    = (mx < HV) && (my < VV);
                e_hs    = (mx >= HV + HF && mx < HV + HF + HS) ? POL : ~POL;
                e_vs    = (my >= VV + VF && my < VV + VF + VS) ? POL : ~POL;
                mx++;
                if (mx == HT) begin
                    mx = 0;
                    my = (my == VT - 1) ? 0 : my + 1;
                end
            end
        end
        #1;
        checkOutput("pixel",       32'(pixel),        32'(e_pixel));
        checkOutput("de",          32'(de),           32'(e_de));
        checkOutput("hsync",       32'(hsync),        32'(e_hs));
        checkOutput("vsync",       32'(vsync),        32'(e_vs));
        checkOutput("frame_start", 32'(frame_start),  32'(e_fs));
        checkOutput("addr",        32'(fb_read_addr), 32'(modelAddr(mx, my)));
        cycle++;
    endtask

    initial begin
        int budget;
        rst = 1'b1; pix_ce = 1'b0;
        mx = 0; my = 0; checkCount = 0; passCount = 0; cycle = 0;
        e_pixel = '0; e_de = 1'b0; e_hs = ~POL; e_vs = ~POL; e_fs = 1'b0;
`ifdef VGA_SCANOUT_BORDER_EN
        foreach (fb_mem[i]) fb_mem[i] = '0;
`else
        foreach (fb_mem[i]) fb_mem[i] = W'($urandom);
`endif

        // Reset held for a few clocks, with and without pix_ce.
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);

        // Free-running raster, slightly more than one frame.
        for (int i = 0; i < HT * VT + 100; i++) applyStimulus(1'b1, 1'b0);

        // Random enable with occasional resets.
        for (int i = 0; i < 3000; i++)
            applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 399) == 0));

        // Enable on alternate clocks for about a frame.
        for (int i = 0; i < 2 * HT * VT + 50; i++) applyStimulus(1'(i % 2), 1'b0);

        // Run to the middle of the visible area, then pulse reset once.
        budget = 2 * HT * VT;
        while (!(mx == HV / 2 + 3 && my == VV / 2 + 1) && budget > 0) begin
            applyStimulus(1'b1, 1'b0);
            budget--;
        end
        checkOutput("mid_frame_reach", 32'(budget > 0), 32'd1);
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 3 * HT; i++) applyStimulus(1'b1, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
